// File: rtl/rx_bit_unstuffer_pkg.sv
// rx_bit_unstuffer_pkg: shared constants for the SIE receive stages
package rx_bit_unstuffer_pkg;
    localparam int USB_STUFF_LEN = 6;
    localparam int USB_BYTE_W = 8;
endpackage

// File: rtl/rx_bit_destuff.sv
// rx_bit_destuff: ones run counter, stuffed-bit drop decision and stuff error pulse
// clk12/RST clock and async reset; in_valid/in_bit decoded bit; pkt_start/pkt_end framing;
// keep/err combinational decision for this cycle; stuff_err registered error pulse
module rx_bit_destuff
    import rx_bit_unstuffer_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic clk12,
    input  logic RST,
    input  logic in_valid,
    input  logic in_bit,
    input  logic pkt_start,
    input  logic pkt_end,
    output logic keep,
    output logic err,
    output logic stuff_err
);
    localparam int CW = $clog2(STUFF_LEN + 1);
    logic [CW-1:0] ones_cnt, base, nxt;
    logic slot;
    always_comb begin
        base = (pkt_start && !pkt_end) ? '0 : ones_cnt;
        slot = base == CW'(STUFF_LEN);
        keep = in_valid && !slot;
        err = in_valid && slot && in_bit;
        nxt = !in_valid ? base : (slot || !in_bit) ? '0 : base + CW'(1);
    end
    always_ff @(posedge clk12 or posedge RST) begin
        if (RST) begin
            ones_cnt <= '0;
            stuff_err <= 1'b0;
        end else begin
            ones_cnt <= pkt_end ? '0 : nxt;
            stuff_err <= err;
        end
    end
endmodule

// File: rtl/rx_bit_unstuffer.sv
// rx_bit_unstuffer: removes stuffed bits, packs bytes LSB-first and reports end-of-packet status
// clk12/RST clock and async reset; in_valid/in_bit decoded bit; pkt_start/pkt_end framing pulses;
// bit_valid/bit_out unstuffed bit; byte_valid/byte_data assembled word; stuff_err violation pulse;
// eop_valid/eop_aligned/eop_err end-of-packet report
module rx_bit_unstuffer
    import rx_bit_unstuffer_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN,
    parameter int BYTE_W = USB_BYTE_W
) (
    input  logic              clk12,
    input  logic              RST,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              pkt_start,
    input  logic              pkt_end,
    output logic              bit_valid,
    output logic              bit_out,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              stuff_err,
    output logic              eop_valid,
    output logic              eop_aligned,
    output logic              eop_err
);
    localparam int BW = $clog2(BYTE_W);
    logic [BW-1:0] bit_cnt, bc_base, bc_next;
    logic [BYTE_W-1:0] sr, word;
    logic err_flag, ef_base, keep, err, last, restart;

    rx_bit_destuff #(.STUFF_LEN(STUFF_LEN)) u_destuff (
        .clk12(clk12),
        .RST(RST),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .pkt_start(pkt_start),
        .pkt_end(pkt_end),
        .keep(keep),
        .err(err),
        .stuff_err(stuff_err)
    );

    // pkt_start alone processes this cycle's bit against cleared state; with pkt_end
    // present the report is taken from the old state and everything is cleared after
    always_comb begin
        restart = pkt_start && !pkt_end;
        bc_base = restart ? '0 : bit_cnt;
        ef_base = !restart && err_flag;
        word = restart ? '0 : sr;
        if (keep) word[bc_base] = in_bit;
        last = keep && bc_base == BW'(BYTE_W - 1);
        bc_next = last ? '0 : bc_base + BW'(keep);
    end

    always_ff @(posedge clk12 or posedge RST) begin
        if (RST) begin
            bit_valid <= 1'b0;
            bit_out <= 1'b0;
            byte_valid <= 1'b0;
            byte_data <= '0;
            sr <= '0;
            bit_cnt <= '0;
            err_flag <= 1'b0;
            eop_valid <= 1'b0;
            eop_aligned <= 1'b0;
            eop_err <= 1'b0;
        end else begin
            bit_valid <= keep;
            bit_out <= keep && in_bit;
            byte_valid <= last;
            byte_data <= last ? word : byte_data;
            sr <= (pkt_start && pkt_end) ? '0 : word;
            bit_cnt <= pkt_end ? '0 : bc_next;
            err_flag <= !pkt_end && (ef_base || err);
            eop_valid <= pkt_end;
            eop_aligned <= pkt_end && bc_next == '0;
            eop_err <= pkt_end && (ef_base || err);
        end
    end
endmodule

// File: tb/tb_rx_bit_unstuffer.sv
// tb_rx_bit_unstuffer: directed vectors checked against a bit-stream model of the unstuffer
module tb_rx_bit_unstuffer;
    localparam int SL = 6;
    localparam int BW = 8;

    logic clk12 = 1'b0;
    logic RST = 1'b1;
    logic in_valid = 1'b0, in_bit = 1'b0, pkt_start = 1'b0, pkt_end = 1'b0;
    logic bit_valid, bit_out, byte_valid, stuff_err, eop_valid, eop_aligned, eop_err;
    logic [BW-1:0] byte_data;

    rx_bit_unstuffer dut (
        .clk12(clk12),
        .RST(RST),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .pkt_start(pkt_start),
        .pkt_end(pkt_end),
        .bit_valid(bit_valid),
        .bit_out(bit_out),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .stuff_err(stuff_err),
        .eop_valid(eop_valid),
        .eop_aligned(eop_aligned),
        .eop_err(eop_err)
    );

    always #5 clk12 = ~clk12;

    int vectors = 0;
    int miscompares = 0;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // model state: length of the current run of ones, bits kept in this packet, error seen
    int run = 0;
    int nbits = 0;
    logic m_err = 1'b0;
    logic [BW-1:0] m_word = '0;
    logic n_bv, n_bo, n_byv, n_se, n_ev, n_ea, n_ee;
    logic [BW-1:0] n_bd = '0;
    logic e_bv, e_bo, e_byv, e_se, e_ev, e_ea, e_ee;
    logic [BW-1:0] e_bd = '0;
    logic chk = 1'b0;

    task automatic model(input logic v, input logic b, input logic s, input logic e);
        {n_bv, n_bo, n_byv, n_se, n_ev, n_ea, n_ee} = '0;
        if (s && !e) begin
            run = 0;
            nbits = 0;
            m_err = 1'b0;
            m_word = '0;
        end
        if (v) begin
            if (run == SL) begin
                run = 0;
                if (b) begin
                    n_se = 1'b1;
                    m_err = 1'b1;
                end
            end else begin
                n_bv = 1'b1;
                n_bo = b;
                m_word[nbits % BW] = b;
                nbits++;
                run = b ? run + 1 : 0;
                if (nbits % BW == 0) begin
                    n_byv = 1'b1;
                    n_bd = m_word;
                end
            end
        end
        if (e) begin
            n_ev = 1'b1;
            n_ea = (nbits % BW) == 0;
            n_ee = m_err;
            run = 0;
            nbits = 0;
            m_err = 1'b0;
            if (s) m_word = '0;
        end
    endtask

    task automatic step(input logic v, input logic b, input logic s, input logic e);
        in_valid = v;
        in_bit = b;
        pkt_start = s;
        pkt_end = e;
        model(v, b, s, e);
        @(posedge clk12);
        #1;
        {e_bv, e_bo, e_byv, e_se, e_ev, e_ea, e_ee} = {n_bv, n_bo, n_byv, n_se, n_ev, n_ea, n_ee};
        e_bd = n_bd;
        chk = 1'b1;
        in_valid = 1'b0;
        pkt_start = 1'b0;
        pkt_end = 1'b0;
    endtask

    always @(negedge clk12) begin
        if (chk) begin
            cmp("bit_valid", 8'(bit_valid), 8'(e_bv));
            if (e_bv) cmp("bit_out", 8'(bit_out), 8'(e_bo));
            cmp("byte_valid", 8'(byte_valid), 8'(e_byv));
            cmp("byte_data", byte_data, e_bd);
            cmp("stuff_err", 8'(stuff_err), 8'(e_se));
            cmp("eop_valid", 8'(eop_valid), 8'(e_ev));
            if (e_ev) begin
                cmp("eop_aligned", 8'(eop_aligned), 8'(e_ea));
                cmp("eop_err", 8'(eop_err), 8'(e_ee));
            end
        end
    end

    task automatic all_zero(input string tag);
        cmp({tag, "_outs"}, {1'b0, bit_valid, bit_out, byte_valid, stuff_err,
                             eop_valid, eop_aligned, eop_err}, 8'h00);
        cmp({tag, "_byte_data"}, byte_data, 8'h00);
    endtask

    task automatic send(input logic [15:0] bits, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            if (gaps) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    int nbv;

    initial begin
        #12;
        all_zero("reset");
        RST = 1'b0;

        // basic byte 1,0,1,0,0,0,1,1
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send(16'b1100_0101, 7, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        cmp("t1_byte_valid", 8'(byte_valid), 8'h01);
        cmp("t1_byte_data", byte_data, 8'hC5);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("t1_eop_aligned", 8'(eop_aligned), 8'h01);
        cmp("t1_eop_err", 8'(eop_err), 8'h00);

        // six ones, stuffed zero, then 0,1
        step(1'b0, 1'b0, 1'b1, 1'b0);
        nbv = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, (i < 6 || i == 8) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (bit_valid) nbv++;
        end
        cmp("t2_bit_count", 8'(nbv), 8'd8);
        cmp("t2_byte_data", byte_data, 8'hBF);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("t2_eop_err", 8'(eop_err), 8'h00);

        // seven ones: violation
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send(16'h007F, 7, 1'b0);
        cmp("t3_stuff_err", 8'(stuff_err), 8'h01);
        cmp("t3_dropped", 8'(bit_valid), 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("t3_pulse_len", 8'(stuff_err), 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("t3_eop_err", 8'(eop_err), 8'h01);
        cmp("t3_eop_aligned", 8'(eop_aligned), 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("t3_err_cleared", 8'(eop_err), 8'h00);

        // eleven bits with idle gaps
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send(16'b101_1001_0110, 11, 1'b1);
        cmp("t4_byte_data", byte_data, 8'h96);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("t4_eop_aligned", 8'(eop_aligned), 8'h00);

        // pkt_start with a bit, pkt_end with the completing bit
        step(1'b1, 1'b1, 1'b1, 1'b0);
        send(16'b10_0110, 6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        cmp("t5_byte_valid", 8'(byte_valid), 8'h01);
        cmp("t5_byte_data", byte_data, 8'h4D);
        cmp("t5_eop_valid", 8'(eop_valid), 8'h01);
        cmp("t5_eop_aligned", 8'(eop_aligned), 8'h01);

        // async reset mid-word
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send(16'b1_0110, 5, 1'b0);
        chk = 1'b0;
        #3;
        RST = 1'b1;
        #1;
        all_zero("t6_async");
        run = 0;
        nbits = 0;
        m_err = 1'b0;
        m_word = '0;
        n_bd = '0;
        @(posedge clk12);
        #1;
        RST = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send(16'b0100_1011, 8, 1'b0);
        cmp("t6_byte_data", byte_data, 8'h4B);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("t6_eop_aligned", 8'(eop_aligned), 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk12);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
